pipeline_ctrl: RTL

- Central hazard and sequencing controller for the 5-stage pipeline registers (IF/ID, ID/EXE, EXE/MEM, MEM/WB) and the PC.
- Detects data hazards and taken branches, and generates per-stage freeze/flush/bubble controls.
- Sequences multi-cycle SRAM accesses with a ready handshake, and freezes the whole pipeline while the MEM stage waits.
- Keeps saturating statistics counters and a sticky memory-timeout flag.

---
 rtl/pipeline_ctrl_pkg.sv | 26 ++
 rtl/hazard_detect.sv | 34 +++
 rtl/pipeline_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline hazard/sequencing controller.
package pipeline_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // ID/EXE control fields that a bubble forces to their inactive value
    typedef struct packed {
        logic       wb_en;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] branch_type;
    } idexe_ctrl_t;

    localparam idexe_ctrl_t NOP_CTRL = '0;

    function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dest,
                                       input logic wb_en);
        return wb_en && (dest != REG_ZERO) && (src == dest);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational RAW hazard detection between the ID sources and the EXE/MEM destinations.
module hazard_detect
    import pipeline_ctrl_pkg::*;
#(
    parameter bit FWD_EN = 1'b1
) (
    input  logic [4:0] src1_id,
    input  logic [4:0] src2_id,
    input  logic       two_src_id,
    input  logic [4:0] exe_dest,
    input  logic       exe_wb_en,
    input  logic       exe_mem_read,
    input  logic [4:0] mem_dest,
    input  logic       mem_wb_en,
    output logic       hazard
);

    logic [1:0][4:0] src;
    logic [1:0]      src_used;
    logic [1:0]      exe_hit;
    logic [1:0]      mem_hit;

    assign src      = {src2_id, src1_id};
    assign src_used = {two_src_id, 1'b1};

    for (genvar i = 0; i < 2; i++) begin : g_src
        assign exe_hit[i] = src_used[i] & reg_match(src[i], exe_dest, exe_wb_en);
        assign mem_hit[i] = src_used[i] & reg_match(src[i], mem_dest, mem_wb_en);
    end

    // With forwarding only a load in EXE cannot be bypassed in time
    assign hazard = FWD_EN ? (exe_mem_read & (|exe_hit)) : ((|exe_hit) | (|mem_hit));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline freeze/flush/bubble controller with SRAM wait sequencing and statistics.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter bit FWD_EN  = 1'b1,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       src1_id,
    input  logic [4:0]       src2_id,
    input  logic             two_src_id,
    input  logic [4:0]       exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_read,
    input  logic [4:0]       mem_dest,
    input  logic             mem_wb_en,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             freeze_front,
    output logic             bubble_idexe,
    output logic             flush_ifid,
    output logic             freeze_back,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WC_W = $clog2(TIMEOUT) + 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

    state_t          state, state_nxt;
    logic [WC_W-1:0] wait_cnt;
    logic            hazard;
    logic            stall_inc, flush_inc;

    hazard_detect #(.FWD_EN(FWD_EN)) u_hazard (
        .src1_id      (src1_id),
        .src2_id      (src2_id),
        .two_src_id   (two_src_id),
        .exe_dest     (exe_dest),
        .exe_wb_en    (exe_wb_en),
        .exe_mem_read (exe_mem_read),
        .mem_dest     (mem_dest),
        .mem_wb_en    (mem_wb_en),
        .hazard       (hazard)
    );

    always_comb begin
        state_nxt    = state;
        freeze_back  = mem_req & ~mem_ready;
        freeze_front = 1'b0;
        bubble_idexe = 1'b0;
        flush_ifid   = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;

        case (state)
            RUN:      if (mem_req && !mem_ready) state_nxt = MEM_WAIT;
            MEM_WAIT: if (mem_ready) state_nxt = RUN;
            default:  state_nxt = RUN;
        endcase

        // A taken branch discards the ID instruction, so its hazard is moot
        if (freeze_back) begin
            freeze_front = 1'b1;
        end else if (branch_taken) begin
            flush_ifid   = 1'b1;
            bubble_idexe = 1'b1;
            flush_inc    = 1'b1;
        end else if (hazard) begin
            freeze_front = 1'b1;
            bubble_idexe = 1'b1;
            stall_inc    = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            wait_cnt  <= '0;
            mem_error <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_nxt;

            if (state == MEM_WAIT && !mem_ready) begin
                if (wait_cnt != WC_LAST) wait_cnt <= wait_cnt + 1'b1;
                if (wait_cnt == WC_LAST) mem_error <= 1'b1;
            end else begin
                wait_cnt <= '0;
            end

            if (stall_inc && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            if (flush_inc && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule
